iso14443a_tag_tx: RTL and testbench

ISO14443A_TAG_TX -- requirements
Module: iso14443a_tag_tx

---
 rtl/iso14443a_tag_tx.sv | 173 +++++++++++++++++
 tb/tb_iso14443a_tag_tx.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/iso14443a_tag_tx.sv
// ISO/IEC 14443-A tag-to-reader transmitter: Manchester-coded load modulation on an
// fc/16 subcarrier with SOF, per-byte odd parity and EOF, fed by a valid/ready byte stream.
`timescale 1ns/1ps
module iso14443a_tag_tx #(
  parameter int SUBC_HALF  = 8,
  parameter int BIT_CYCLES = 128,
  parameter bit PARITY_EN  = 1'b1
) (
  input  logic       osc_clk,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_last,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       mod_out,
  output logic       busy,
  output logic       underrun
);
  // Handshake: a byte (tx_data, tx_last) transfers on any rising edge where tx_valid and
  // tx_ready are both high; tx_ready does not depend on tx_valid, and nothing is sampled
  // from tx_data/tx_last on cycles where the transfer does not happen.

  localparam int PW = $clog2(BIT_CYCLES);
  localparam int SW = $clog2(2 * SUBC_HALF);

  typedef enum logic [2:0] {IDLE, SOF, DATA, PAR, EOF} state_t;

  state_t        state;
  logic [PW-1:0] phase;
  logic [2:0]    bit_cnt;
  logic [7:0]    shift_reg;
  logic          par_bit;
  logic          cur_last;
  logic [7:0]    hold_data;
  logic          hold_last;
  logic          hold_full;
  logic          last_taken;

  logic          accept;
  logic          bit_end;
  logic          byte_end;
  logic          cur_bit;
  logic          first_half;
  logic          sub_on;
  logic          mod_next;
  logic          load_en;
  logic [7:0]    load_data;
  logic          load_last;
  logic [SW-1:0] sub_phase;

  assign tx_ready = !reset && !hold_full && !last_taken && (state != EOF);
  assign accept   = tx_valid && tx_ready;
  assign bit_end  = (phase == PW'(BIT_CYCLES - 1));
  assign byte_end = bit_end && ((state == PAR) ||
                    (state == DATA && bit_cnt == 3'd7 && !PARITY_EN));

  // Subcarrier and bit periods are powers of two, so the low phase bits are the
  // position inside one subcarrier period.
  assign sub_phase  = phase[SW-1:0];
  assign sub_on     = (sub_phase < SW'(SUBC_HALF));
  assign first_half = (phase < PW'(BIT_CYCLES / 2));

  always_comb begin
    cur_bit = 1'b0;
    case (state)
      SOF:     cur_bit = 1'b1;
      DATA:    cur_bit = shift_reg[0];
      PAR:     cur_bit = par_bit;
      default: cur_bit = 1'b0;
    endcase
  end

  // Logic 1 modulates the first half of the bit period, logic 0 the second half.
  assign mod_next = (state inside {SOF, DATA, PAR}) && sub_on && (cur_bit == first_half);

  // A new byte enters the shift register on the IDLE handshake or at a byte boundary,
  // preferring the holding register and otherwise taking a byte arriving that very cycle.
  always_comb begin
    load_en   = 1'b0;
    load_data = tx_data;
    load_last = tx_last;
    if (state == IDLE) begin
      load_en = accept;
    end else if (byte_end && !cur_last) begin
      if (hold_full) begin
        load_en   = 1'b1;
        load_data = hold_data;
        load_last = hold_last;
      end else begin
        load_en = accept;
      end
    end
  end

  always_ff @(posedge osc_clk) begin
    if (reset) begin
      state      <= IDLE;
      phase      <= '0;
      bit_cnt    <= '0;
      shift_reg  <= '0;
      par_bit    <= 1'b0;
      cur_last   <= 1'b0;
      hold_data  <= '0;
      hold_last  <= 1'b0;
      hold_full  <= 1'b0;
      last_taken <= 1'b0;
      mod_out    <= 1'b0;
      busy       <= 1'b0;
      underrun   <= 1'b0;
    end else begin
      mod_out  <= mod_next;
      underrun <= 1'b0;

      if (accept && tx_last) last_taken <= 1'b1;
      if (state != IDLE) phase <= bit_end ? '0 : phase + PW'(1);

      if (accept && state != IDLE && !(byte_end && !hold_full)) begin
        hold_data <= tx_data;
        hold_last <= tx_last;
        hold_full <= 1'b1;
      end

      case (state)
        IDLE: begin
          phase <= '0;
          if (accept) begin
            state <= SOF;
            busy  <= 1'b1;
          end
        end
        SOF: if (bit_end) state <= DATA;
        DATA: begin
          if (bit_end) begin
            if (bit_cnt != 3'd7) begin
              bit_cnt   <= bit_cnt + 3'd1;
              shift_reg <= {1'b0, shift_reg[7:1]};
            end else if (PARITY_EN) begin
              state <= PAR;
            end
          end
        end
        PAR: ;
        EOF: begin
          if (bit_end) begin
            state      <= IDLE;
            busy       <= 1'b0;
            last_taken <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase

      if (byte_end) begin
        if (cur_last) begin
          state <= EOF;
        end else if (hold_full || accept) begin
          state <= DATA;
          if (hold_full) hold_full <= 1'b0;
        end else begin
          underrun <= 1'b1;
          state    <= EOF;
        end
      end

      if (load_en) begin
        shift_reg <= load_data;
        par_bit   <= ~^load_data;
        cur_last  <= load_last;
        bit_cnt   <= '0;
      end
    end
  end
endmodule

// File: tb/tb_iso14443a_tag_tx.sv
// Bench for iso14443a_tag_tx: two instances (parity on/off) checked every cycle against a
// frame-level model built from the byte list, plus literal decode and timing expectations.
`timescale 1ns/1ps
module tb_iso14443a_tag_tx;
  localparam int BC = 128;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] t_data  [2];
  logic       t_last  [2];
  logic       t_valid [2];
  logic       t_ready [2];
  logic       t_mod   [2];
  logic       t_busy  [2];
  logic       t_und   [2];

  int cyc = 0;
  int vectors = 0;
  int miscompares = 0;

  // Frame model: bit list (SOF first), start cycle, expected underrun, reset cut-off.
  bit m_active [2];
  int m_start  [2];
  int m_abort  [2];
  int m_nbits  [2];
  bit m_und    [2];
  bit m_bits   [2][64];

  int         busy_cnt [2];
  int         und_cnt  [2];
  bit         h1 [32];
  bit         h2 [32];
  bit [127:0] sof_wave;

  iso14443a_tag_tx #(.SUBC_HALF(8), .BIT_CYCLES(128), .PARITY_EN(1'b1)) dut_par (
    .osc_clk(clk), .reset(reset), .tx_data(t_data[0]), .tx_last(t_last[0]),
    .tx_valid(t_valid[0]), .tx_ready(t_ready[0]), .mod_out(t_mod[0]),
    .busy(t_busy[0]), .underrun(t_und[0]));

  iso14443a_tag_tx #(.SUBC_HALF(8), .BIT_CYCLES(128), .PARITY_EN(1'b0)) dut_nopar (
    .osc_clk(clk), .reset(reset), .tx_data(t_data[1]), .tx_last(t_last[1]),
    .tx_valid(t_valid[1]), .tx_ready(t_ready[1]), .mod_out(t_mod[1]),
    .busy(t_busy[1]), .underrun(t_und[1]));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation did not finish in time (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s @cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [2:0] model_out(input int i, input int t);
    int   rel, k, ph;
    logic m, b, u;
    if (!m_active[i] || t < m_start[i] || t >= m_abort[i]) return 3'b000;
    rel = t - m_start[i];
    b = (rel < (m_nbits[i] + 1) * BC);
    u = m_und[i] && (rel == m_nbits[i] * BC);
    m = 1'b0;
    if (rel >= 1 && rel - 1 < m_nbits[i] * BC) begin
      k  = rel - 1;
      ph = k % BC;
      m  = ((ph % 16) < 8) && (m_bits[i][k / BC] == (ph < BC / 2));
    end
    return {m, b, u};
  endfunction

  task automatic tick();
    logic [2:0] e;
    int k, p, ph;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      e = model_out(i, cyc);
      check($sformatf("out%0d {mod,busy,underrun}", i), {t_mod[i], t_busy[i], t_und[i]}, e);
      if (t_busy[i] === 1'b1) busy_cnt[i]++;
      if (t_und[i] === 1'b1) und_cnt[i]++;
    end
    if (m_active[0] && cyc > m_start[0]) begin
      k  = cyc - m_start[0] - 1;
      p  = k / BC;
      ph = k % BC;
      if (p < 32 && t_mod[0] === 1'b1) begin
        if (ph < BC / 2) h1[p] = 1'b1;
        else             h2[p] = 1'b1;
      end
      if (p == 0) sof_wave[ph] = (t_mod[0] === 1'b1);
    end
  endtask

  task automatic start_frame(input int i, input logic [7:0] b [4], input int n, input bit end_last);
    int idx;
    m_active[i] = 1'b0;
    m_abort[i]  = 32'h7fff_ffff;
    m_und[i]    = !end_last;
    m_bits[i][0] = 1'b1;
    idx = 1;
    for (int j = 0; j < n; j++) begin
      for (int q = 0; q < 8; q++) begin
        m_bits[i][idx] = b[j][q];
        idx++;
      end
      if (i == 0) begin
        m_bits[i][idx] = ~^b[j];
        idx++;
      end
    end
    m_nbits[i]  = idx;
    busy_cnt[i] = 0;
    und_cnt[i]  = 0;
    for (int p = 0; p < 32; p++) begin
      h1[p] = 1'b0;
      h2[p] = 1'b0;
    end
    sof_wave = '0;
  endtask

  task automatic push_byte(input int i, input logic [7:0] d, input logic l);
    int waited = 0;
    t_data[i]  = d;
    t_last[i]  = l;
    t_valid[i] = 1'b1;
    while (t_ready[i] !== 1'b1 && waited < 3000) begin
      tick();
      waited++;
    end
    check($sformatf("tx_ready%0d before accept", i), t_ready[i], 1'b1);
    if (!m_active[i]) begin
      m_start[i]  = cyc + 1;
      m_active[i] = 1'b1;
    end
    tick();
    t_valid[i] = 1'b0;
    t_data[i]  = 8'($urandom_range(0, 255));
    t_last[i]  = 1'($urandom_range(0, 1));
  endtask

  task automatic wait_frame_end(input int i);
    int target;
    target = m_start[i] + (m_nbits[i] + 1) * BC + 3;
    while (cyc < target) tick();
  endtask

  task automatic run_frame(input int i, input logic [7:0] b [4], input int n, input bit end_last);
    start_frame(i, b, n, end_last);
    repeat ($urandom_range(0, 10)) tick();
    for (int j = 0; j < n; j++) begin
      if (j > 0) repeat ($urandom_range(0, 20)) tick();
      push_byte(i, b[j], (j == n - 1) && end_last);
    end
    wait_frame_end(i);
    check($sformatf("busy%0d cycles", i), busy_cnt[i], (m_nbits[i] + 1) * BC);
    check($sformatf("underrun%0d pulses", i), und_cnt[i], end_last ? 0 : 1);
    check($sformatf("tx_ready%0d in idle", i), t_ready[i], 1'b1);
  endtask

  task automatic check_decode(input string exp_s);
    byte c;
    for (int p = 0; p < exp_s.len(); p++) begin
      if (h1[p] && !h2[p])      c = "1";
      else if (!h1[p] && h2[p]) c = "0";
      else if (!h1[p] && !h2[p]) c = "E";
      else                      c = "X";
      check($sformatf("decoded period %0d", p), c, exp_s[p]);
    end
  endtask

  initial begin
    logic [7:0] b [4];
    int         n;
    bit         el;
    int         target;
    int         inst;

    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      t_data[i] = '0; t_last[i] = 1'b0; t_valid[i] = 1'b0;
      m_active[i] = 1'b0; m_abort[i] = 32'h7fff_ffff; m_start[i] = 0; m_nbits[i] = 0;
    end

    // Reset: tx_ready held low, then high on the first cycle out of reset.
    repeat (4) begin
      tick();
      check("tx_ready0 in reset", t_ready[0], 1'b0);
      check("tx_ready1 in reset", t_ready[1], 1'b0);
    end
    reset = 1'b0;
    tick();
    check("tx_ready0 after reset", t_ready[0], 1'b1);
    check("tx_ready1 after reset", t_ready[1], 1'b1);

    // Single byte 0x26 with parity.
    b = '{8'h26, 8'h00, 8'h00, 8'h00};
    run_frame(0, b, 1, 1'b1);
    check_decode({"1", "01100100", "0", "E"});
    check("0x26 busy length", busy_cnt[0], 1408);
    check("SOF subcarrier waveform", sof_wave, {64'h0, 64'h00FF_00FF_00FF_00FF});

    // Two bytes back-to-back: hold register path, tx_ready behaviour around the last byte.
    b = '{8'h04, 8'h00, 8'h00, 8'h00};
    start_frame(0, b, 2, 1'b1);
    push_byte(0, 8'h04, 1'b0);
    check("tx_ready during SOF", t_ready[0], 1'b1);
    push_byte(0, 8'h00, 1'b1);
    check("tx_ready after last accept", t_ready[0], 1'b0);
    wait_frame_end(0);
    check_decode({"1", "00100000", "0", "00000000", "1", "E"});
    check("two-byte busy length", busy_cnt[0], 2560);

    // Underrun: 0x93 without tx_last and nothing after it.
    b = '{8'h93, 8'h00, 8'h00, 8'h00};
    run_frame(0, b, 1, 1'b0);
    check("underrun pulse count", und_cnt[0], 1);
    check("underrun frame length", busy_cnt[0], 1408);

    // No parity: 0xFF.
    b = '{8'hFF, 8'h00, 8'h00, 8'h00};
    run_frame(1, b, 1, 1'b1);
    check("no-parity busy length", busy_cnt[1], 1280);

    // Reset during DATA bit 3 with a second byte buffered.
    b = '{8'hA5, 8'h3C, 8'h00, 8'h00};
    start_frame(0, b, 2, 1'b1);
    push_byte(0, 8'hA5, 1'b0);
    push_byte(0, 8'h3C, 1'b1);
    target = m_start[0] + 4 * BC + 50;
    while (cyc < target) tick();
    reset = 1'b1;
    m_abort[0] = cyc + 1;
    m_abort[1] = cyc + 1;
    repeat (3) begin
      tick();
      check("tx_ready0 in mid-frame reset", t_ready[0], 1'b0);
    end
    reset = 1'b0;
    tick();
    check("tx_ready0 after mid-frame reset", t_ready[0], 1'b1);
    check("no underrun on reset", und_cnt[0], 0);
    b = '{8'h5A, 8'h00, 8'h00, 8'h00};
    run_frame(0, b, 1, 1'b1);

    // Randomized frames on both instances.
    for (int r = 0; r < 8; r++) begin
      inst = r % 2;
      n    = $urandom_range(1, 3);
      el   = ($urandom_range(0, 3) != 0);
      for (int j = 0; j < 4; j++) b[j] = 8'($urandom_range(0, 255));
      run_frame(inst, b, n, el);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
